issue_hold_buffer: RTL and testbench
====================================

ISSUE_HOLD_BUFFER -- requirements
Module: issue_hold_buffer

Interface
REQ-001 SHALL have parameter LOAD_LATENCY, default 1, number of bubble cycles inserted per stall; legal range 1..15.
REQ-002 SHALL have parameter PAYLOAD_W, default 64, width of the decoded operand/immediate payload.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_valid  input  1  decode stage presents an instruction.
REQ-006 SHALL have port dec_opcode  input  OPCODE_W  decoded opcode, width from the common params header.
REQ-007 SHALL have port dec_payload  input  PAYLOAD_W  decoded operands.
REQ-008 SHALL have port stall_req  input  1  load-use hazard on the presented instruction, from the hazard detector.
REQ-009 SHALL have port flush  input  1  pipeline kill from branch resolution.
REQ-010 SHALL have port dec_ready  output  1  decode may advance; also the PC-freeze complement.
REQ-011 SHALL have port exe_valid  output  1  execute-stage instruction is real, not a bubble.
REQ-012 SHALL have port exe_opcode  output  OPCODE_W  opcode to execute, all-zero for a bubble.
REQ-013 SHALL have port exe_payload  output  PAYLOAD_W  operands to execute, all-zero for a bubble.

Function
REQ-014 SHALL implement states PASS and HOLD, plus a hold register (valid, opcode, payload) and a down-counter cnt of width clog2(LOAD_LATENCY+1).
REQ-015 In PASS without stall_req or flush, each edge SHALL register dec_valid/dec_opcode/dec_payload into exe_*: one-cycle latency, no gaps.
REQ-016 dec_ready SHALL be combinational: 1 in PASS when stall_req=0; 0 in PASS when stall_req=1; 0 throughout HOLD.
REQ-017 In PASS with stall_req=1 and dec_valid=1 at cycle t, the edge SHALL capture dec_* into the hold register, drive a bubble to exe_*, load cnt=LOAD_LATENCY, and enter HOLD.
REQ-018 In PASS with stall_req=1 and dec_valid=0, the block SHALL register a bubble and remain in PASS.
REQ-019 In HOLD with cnt>1, each edge SHALL drive a bubble and decrement cnt.
REQ-020 In HOLD with cnt=1, the edge SHALL drive the held instruction to exe_*, clear the hold register, and enter PASS.
REQ-021 Net timing: bubbles in cycles t+1..t+LOAD_LATENCY; held instruction in cycle t+LOAD_LATENCY+1; dec_ready low in cycles t..t+LOAD_LATENCY.
REQ-022 stall_req in HOLD SHALL be ignored; cnt is not reloaded.
REQ-023 dec_* SHALL be ignored whenever dec_ready=0, except for the capture in REQ-017.
REQ-024 flush SHALL take priority over stall_req in every state: the next edge drives a bubble, clears the hold register and cnt, and enters PASS.
REQ-025 A bubble SHALL be exe_valid=0 with exe_opcode and exe_payload all-zero.
REQ-026 LOAD_LATENCY outside 1..15 SHALL cause an elaboration-time error.

Reset
REQ-027 While rst=1 at an edge, the block SHALL enter PASS, set cnt=0, clear the hold register, and set exe_valid=0, exe_opcode=0, exe_payload=0.
REQ-028 rst SHALL override flush and stall_req, including mid-HOLD; the held instruction is discarded.
REQ-029 After reset, dec_ready SHALL follow REQ-016 from the first cycle with rst=0.

Configuration
REQ-030 With macro ISSUE_HOLD_STATS_EN defined, the block SHALL add output stall_cycles (32 bits, reset 0), incremented once per edge on which a bubble is driven because of a stall, saturating at 0xFFFFFFFF; flush bubbles are not counted.
REQ-031 Without ISSUE_HOLD_STATS_EN, the stall_cycles port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 LOAD_LATENCY=1: opcodes A,B,C streamed with no stall -> exe shows A,B,C in consecutive cycles, each one cycle after presentation, dec_ready constantly 1.
REQ-033 LOAD_LATENCY=1: stall_req with B at cycle 5 -> exe_valid=0 at cycle 6, B at cycle 7, dec_ready=0 in cycles 5-6; next instruction C appears at cycle 8.
REQ-034 LOAD_LATENCY=3: stall at cycle 10 -> bubbles in cycles 11-13, held instruction at 14; stall_req pulsed at cycle 12 -> no change.
REQ-035 LOAD_LATENCY=3: flush at cycle 12 during HOLD -> bubble at 13, held instruction never issued, PASS and dec_ready=1 at 13; flush with stall_req together in PASS -> no HOLD entry.
REQ-036 rst asserted mid-HOLD -> all outputs zero and PASS next cycle; with ISSUE_HOLD_STATS_EN defined, stall_cycles=0 after reset, and equals 4 after one LOAD_LATENCY=3 stall plus one LOAD_LATENCY=1 stall.

Source files
------------

// File: rtl/issue_hold_buffer_if.sv
// Decode-to-execute issue handshake bundle for issue_hold_buffer.
// master = decode/hazard side, slave = the hold buffer.
interface issue_hold_if #(
  parameter int OPCODE_W  = 7,
  parameter int PAYLOAD_W = 64
);
  logic                 dec_valid;
  logic [OPCODE_W-1:0]  dec_opcode;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 stall_req;
  logic                 flush;
  logic                 dec_ready;
  logic                 exe_valid;
  logic [OPCODE_W-1:0]  exe_opcode;
  logic [PAYLOAD_W-1:0] exe_payload;

  modport master (
    output dec_valid,
    output dec_opcode,
    output dec_payload,
    output stall_req,
    output flush,
    input  dec_ready,
    input  exe_valid,
    input  exe_opcode,
    input  exe_payload
  );

  modport slave (
    input  dec_valid,
    input  dec_opcode,
    input  dec_payload,
    input  stall_req,
    input  flush,
    output dec_ready,
    output exe_valid,
    output exe_opcode,
    output exe_payload
  );
endinterface

// File: rtl/issue_hold_buffer.sv
// Load-use stall buffer between decode and execute; inserts LOAD_LATENCY bubbles.
// Define ISSUE_HOLD_STATS_EN to add the stall_cycles counter output.
module issue_hold_buffer #(
  parameter int LOAD_LATENCY = 1,
  parameter int PAYLOAD_W    = 64,
  parameter int OPCODE_W     = 7
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ISSUE_HOLD_STATS_EN
  output logic [31:0] stall_cycles,
`endif
  issue_hold_if.slave bus
);

  localparam int CNT_W = $clog2(LOAD_LATENCY + 1);
  localparam logic [CNT_W-1:0] LL_C = CNT_W'(LOAD_LATENCY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15) begin : g_bad_ll
    $error("issue_hold_buffer: LOAD_LATENCY must be 1..15");
  end

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt;

  logic                 r_hold_v;
  logic [OPCODE_W-1:0]  r_hold_op;
  logic [PAYLOAD_W-1:0] r_hold_pl;
  logic                 w_hold_v;
  logic [OPCODE_W-1:0]  w_hold_op;
  logic [PAYLOAD_W-1:0] w_hold_pl;

  logic                 r_exe_v;
  logic [OPCODE_W-1:0]  r_exe_op;
  logic [PAYLOAD_W-1:0] r_exe_pl;
  logic                 w_exe_v;
  logic [OPCODE_W-1:0]  w_exe_op;
  logic [PAYLOAD_W-1:0] w_exe_pl;

  logic                 w_stall_bub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PASS;
      r_cnt     <= '0;
      r_hold_v  <= 1'b0;
      r_hold_op <= '0;
      r_hold_pl <= '0;
      r_exe_v   <= 1'b0;
      r_exe_op  <= '0;
      r_exe_pl  <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_hold_v  <= w_hold_v;
      r_hold_op <= w_hold_op;
      r_hold_pl <= w_hold_pl;
      r_exe_v   <= w_exe_v;
      r_exe_op  <= w_exe_op;
      r_exe_pl  <= w_exe_pl;
    end
  end

  // Everything defaults to a bubble; only real issues override exe_*.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_hold_v    = r_hold_v;
    w_hold_op   = r_hold_op;
    w_hold_pl   = r_hold_pl;
    w_exe_v     = 1'b0;
    w_exe_op    = '0;
    w_exe_pl    = '0;
    w_stall_bub = 1'b0;
    if (bus.flush) begin
      w_state   = PASS;
      w_cnt     = '0;
      w_hold_v  = 1'b0;
      w_hold_op = '0;
      w_hold_pl = '0;
    end else begin
      unique case (r_state)
        PASS: begin
          if (bus.stall_req) begin
            if (bus.dec_valid) begin
              w_hold_v    = 1'b1;
              w_hold_op   = bus.dec_opcode;
              w_hold_pl   = bus.dec_payload;
              w_cnt       = LL_C;
              w_state     = HOLD;
              w_stall_bub = 1'b1;
            end
          end else if (bus.dec_valid) begin
            w_exe_v  = 1'b1;
            w_exe_op = bus.dec_opcode;
            w_exe_pl = bus.dec_payload;
          end
        end
        HOLD: begin
          if (r_cnt > ONE_C) begin
            w_cnt       = r_cnt - ONE_C;
            w_stall_bub = 1'b1;
          end else begin
            w_exe_v   = r_hold_v;
            w_exe_op  = r_hold_op;
            w_exe_pl  = r_hold_pl;
            w_hold_v  = 1'b0;
            w_hold_op = '0;
            w_hold_pl = '0;
            w_cnt     = '0;
            w_state   = PASS;
          end
        end
      endcase
    end
  end

  assign bus.dec_ready   = (r_state == PASS) && !bus.stall_req;
  assign bus.exe_valid   = r_exe_v;
  assign bus.exe_opcode  = r_exe_op;
  assign bus.exe_payload = r_exe_pl;

`ifdef ISSUE_HOLD_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall_bub && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_issue_hold_buffer.sv
// Table-driven scoreboard bench for issue_hold_buffer, LOAD_LATENCY 1 and 3.
// Stats checks are compiled in when ISSUE_HOLD_STATS_EN is defined.
module tb_issue_hold_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_hold_if #(.OPCODE_W(7), .PAYLOAD_W(64)) bus1 ();
  issue_hold_if #(.OPCODE_W(7), .PAYLOAD_W(64)) bus3 ();

`ifdef ISSUE_HOLD_STATS_EN
  logic [31:0] sc1;
  logic [31:0] sc3;
`endif

  issue_hold_buffer #(
    .LOAD_LATENCY(1), .PAYLOAD_W(64), .OPCODE_W(7)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
`ifdef ISSUE_HOLD_STATS_EN
    .stall_cycles(sc1),
`endif
    .bus(bus1.slave)
  );

  issue_hold_buffer #(
    .LOAD_LATENCY(3), .PAYLOAD_W(64), .OPCODE_W(7)
  ) u_dut3 (
    .clk(clk),
    .rst(rst),
`ifdef ISSUE_HOLD_STATS_EN
    .stall_cycles(sc3),
`endif
    .bus(bus3.slave)
  );

  typedef struct {
    int sel;
    bit rst;
    bit v;
    int op;
    bit st;
    bit fl;
    bit crdy;
    bit rdy;
    bit ev;
    int eop;
  } vec_t;

  typedef struct {
    int sel;
    bit ev;
    int eop;
    int idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   vidx  = 0;

  function automatic logic [63:0] pl(input logic [6:0] op);
    return {8'hA5, 49'h0, op};
  endfunction

  function automatic vec_t mk(int sel, bit r, bit v, int op, bit st,
                              bit fl, bit crdy, bit rdy, bit ev, int eop);
    vec_t x;
    x.sel = sel; x.rst = r; x.v = v; x.op = op; x.st = st;
    x.fl = fl; x.crdy = crdy; x.rdy = rdy; x.ev = ev; x.eop = eop;
    return x;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    logic [63:0] ep;
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    ep = e.ev ? pl(7'(e.eop)) : 64'h0;
    if (e.sel == 0) begin
      chk("exe_valid", e.idx, 64'(bus1.exe_valid), 64'(e.ev));
      chk("exe_opcode", e.idx, 64'(bus1.exe_opcode), 64'(e.eop));
      chk("exe_payload", e.idx, bus1.exe_payload, ep);
    end else begin
      chk("exe_valid", e.idx, 64'(bus3.exe_valid), 64'(e.ev));
      chk("exe_opcode", e.idx, 64'(bus3.exe_opcode), 64'(e.eop));
      chk("exe_payload", e.idx, bus3.exe_payload, ep);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    pop_check();
    rst = v.rst;
    bus1.dec_valid   = (v.sel == 0) ? v.v : 1'b0;
    bus1.dec_opcode  = (v.sel == 0) ? 7'(v.op) : 7'h0;
    bus1.dec_payload = (v.sel == 0) ? pl(7'(v.op)) : 64'h0;
    bus1.stall_req   = (v.sel == 0) ? v.st : 1'b0;
    bus1.flush       = (v.sel == 0) ? v.fl : 1'b0;
    bus3.dec_valid   = (v.sel == 1) ? v.v : 1'b0;
    bus3.dec_opcode  = (v.sel == 1) ? 7'(v.op) : 7'h0;
    bus3.dec_payload = (v.sel == 1) ? pl(7'(v.op)) : 64'h0;
    bus3.stall_req   = (v.sel == 1) ? v.st : 1'b0;
    bus3.flush       = (v.sel == 1) ? v.fl : 1'b0;
    #1;
    if (v.crdy) begin
      if (v.sel == 0) chk("dec_ready", vidx, 64'(bus1.dec_ready), 64'(v.rdy));
      else            chk("dec_ready", vidx, 64'(bus3.dec_ready), 64'(v.rdy));
    end
    e.sel = v.sel; e.ev = v.ev; e.eop = v.eop; e.idx = vidx;
    sb.push_back(e);
    vidx++;
  endtask

  task automatic drain();
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    bus1.dec_valid = 1'b0; bus1.dec_opcode = '0; bus1.dec_payload = '0;
    bus1.stall_req = 1'b0; bus1.flush = 1'b0;
    bus3.dec_valid = 1'b0; bus3.dec_opcode = '0; bus3.dec_payload = '0;
    bus3.stall_req = 1'b0; bus3.flush = 1'b0;

    // sel rst v op st fl crdy rdy ev eop
    tbl.push_back(mk(0,1,0,'h00,0,0,0,0,0,'h00));
    tbl.push_back(mk(0,1,1,'h7F,1,1,0,0,0,'h00));
    tbl.push_back(mk(0,0,1,'h11,0,0,1,1,1,'h11));
    tbl.push_back(mk(0,0,1,'h12,0,0,1,1,1,'h12));
    tbl.push_back(mk(0,0,1,'h13,0,0,1,1,1,'h13));
    tbl.push_back(mk(0,0,1,'h22,1,0,1,0,0,'h00));
    tbl.push_back(mk(0,0,1,'h22,0,0,1,0,1,'h22));
    tbl.push_back(mk(0,0,1,'h23,0,0,1,1,1,'h23));
    tbl.push_back(mk(0,0,0,'h2A,1,0,1,0,0,'h00));
    tbl.push_back(mk(0,0,1,'h24,0,0,1,1,1,'h24));
    tbl.push_back(mk(0,0,1,'h25,1,1,1,0,0,'h00));
    tbl.push_back(mk(0,0,1,'h26,0,0,1,1,1,'h26));
    tbl.push_back(mk(0,0,0,'h55,0,0,1,1,0,'h00));
    tbl.push_back(mk(1,0,1,'h31,1,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h59,1,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,1,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,0,1,'h31));
    tbl.push_back(mk(1,0,1,'h32,0,0,1,1,1,'h32));
    tbl.push_back(mk(1,0,1,'h41,1,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,1,1,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h42,0,0,1,1,1,'h42));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,1,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,1,0,'h00));
    tbl.push_back(mk(1,0,1,'h43,1,1,1,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h44,0,0,1,1,1,'h44));
    tbl.push_back(mk(1,0,1,'h51,1,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,0,0,'h00));
    tbl.push_back(mk(1,1,0,'h00,0,0,1,0,0,'h00));
    tbl.push_back(mk(1,0,1,'h52,0,0,1,1,1,'h52));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,1,0,'h00));
    tbl.push_back(mk(1,0,0,'h00,0,0,1,1,0,'h00));

    foreach (tbl[i]) apply(tbl[i]);
    drain();

`ifdef ISSUE_HOLD_STATS_EN
    apply(mk(0,1,0,'h00,0,0,0,0,0,'h00));
    apply(mk(0,0,1,'h61,1,0,1,0,0,'h00));
    chk("stall_cycles1_rst", vidx, 64'(sc1), 64'd0);
    chk("stall_cycles3_rst", vidx, 64'(sc3), 64'd0);
    apply(mk(0,0,0,'h00,0,0,1,0,1,'h61));
    apply(mk(1,0,1,'h62,1,0,1,0,0,'h00));
    apply(mk(1,0,0,'h00,0,0,1,0,0,'h00));
    apply(mk(1,0,0,'h00,0,0,1,0,0,'h00));
    apply(mk(1,0,0,'h00,0,0,1,0,1,'h62));
    apply(mk(1,0,0,'h00,0,0,1,1,0,'h00));
    drain();
    chk("stall_cycles1", vidx, 64'(sc1), 64'd1);
    chk("stall_cycles3", vidx, 64'(sc3), 64'd3);
    chk("stall_cycles_sum", vidx, 64'(sc1) + 64'(sc3), 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
